// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models fixed MD latency with a
// down-counter and exposes busy/md_active so the hazard unit can stall MD ops in D.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic        md_active,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;
    logic        pwe_q, pwe_d;

    logic [63:0] a_ext, b_ext, prod;
    logic        sgn, a_neg, b_neg, div_zero;
    logic [31:0] abs_a, abs_b, div_b, q_u, r_u, quo, rem;

    // One 64x64 multiplier serves both flavours: the low 64 bits of the product of
    // sign- or zero-extended operands are the correct 64-bit result either way.
    always_comb begin
        sgn      = (md_op == OP_MULT) || (md_op == OP_DIV);
        a_ext    = {(sgn ? {32{src_a[31]}} : 32'd0), src_a};
        b_ext    = {(sgn ? {32{src_b[31]}} : 32'd0), src_b};
        prod     = a_ext * b_ext;
        a_neg    = sgn && src_a[31];
        b_neg    = sgn && src_b[31];
        abs_a    = a_neg ? (32'd0 - src_a) : src_a;
        abs_b    = b_neg ? (32'd0 - src_b) : src_b;
        div_zero = (src_b == 32'd0);
        div_b    = div_zero ? 32'd1 : abs_b;
        q_u      = abs_a / div_b;
        r_u      = abs_a % div_b;
        // Magnitude divide then sign fix; MIN/-1 wraps naturally to 0x80000000 rem 0.
        quo      = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        rem      = a_neg ? (32'd0 - r_u) : r_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwe_d   = pwe_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            phi_d   = prod[63:32];
                            plo_d   = prod[31:0];
                            pwe_d   = 1'b1;
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_d   = rem;
                            plo_d   = quo;
                            pwe_d   = !div_zero;
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (pwe_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign md_active = start | busy;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_data   = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected commits, a negedge
// monitor checks HI/LO hold during busy and the committed values/latency.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        rd_hi = 1'b0;
    logic        busy, md_active;
    logic [31:0] hi, lo, rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi), .busy(busy),
        .md_active(md_active), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one command for one cycle, starting at a negedge; returns at the next negedge.
    task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = c;
        src_a = a;
        src_b = b;
        #1;
        chk("md_active_start", {31'd0, md_active}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd7;
    endtask

    task automatic push(input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.pre_hi = ph; e.pre_lo = pl; e.hi = h; e.lo = l; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy still high after %0d cycles, expected fall", n);
        end
    endtask

    // Monitor: counts busy cycles, checks architectural HI/LO are held, pops on busy fall.
    logic pbusy = 1'b0;
    int   cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            if (!pbusy) cyc = 0;
            cyc++;
            if (sb.size() > 0) begin
                e = sb[0];
                chk("hold_hi", hi, e.pre_hi);
                chk("hold_lo", lo, e.pre_lo);
            end
        end else if (pbusy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL commit: unexpected busy fall, expected none pending");
            end else begin
                e = sb.pop_front();
                chk("commit_hi", hi, e.hi);
                chk("commit_lo", lo, e.lo);
                chk("busy_cycles", 32'(cyc), 32'(e.cyc));
            end
        end
        pbusy = (busy === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Arbitrary activity, then a 2-cycle reset.
        op(3'd4, 32'h1234, 32'd0);
        op(3'd5, 32'h5678, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_md_active", {31'd0, md_active}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // MULT -3 * 5
        push(32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        op(3'd0, 32'hFFFFFFFD, 32'd5);
        chk("md_active_busy1", {31'd0, md_active}, 32'd1);
        wait_idle();

        // DIV -7 / 2, issued in the first idle cycle (back-to-back)
        push(32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        op(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        // DIVU 7 / 2
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3, 10);
        op(3'd3, 32'd7, 32'd2);
        wait_idle();

        // DIVU by zero leaves HI/LO alone
        op(3'd4, 32'h11, 32'd0);
        chk("mthi_11", hi, 32'h11);
        op(3'd5, 32'h22, 32'd0);
        chk("mtlo_22", lo, 32'h22);
        push(32'h11, 32'h22, 32'h11, 32'h22, 10);
        op(3'd3, 32'd5, 32'd0);
        wait_idle();

        // MTHI then immediate MULTU
        op(3'd4, 32'hDEADBEEF, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        rd_hi = 1'b1; #1;
        chk("rd_data_hi", rd_data, 32'hDEADBEEF);
        rd_hi = 1'b0; #1;
        chk("rd_data_lo", rd_data, 32'h22);
        push(32'hDEADBEEF, 32'h22, 32'd1, 32'hFFFFFFFE, 5);
        op(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle();

        // MULT 2*3 with a stray MTLO in busy cycle 2
        push(32'd1, 32'hFFFFFFFE, 32'd0, 32'd6, 5);
        op(3'd0, 32'd2, 32'd3);
        @(negedge clk);
        op(3'd5, 32'h55, 32'd0);
        wait_idle();

        // DIV overflow case MIN / -1
        push(32'd0, 32'd6, 32'd0, 32'h80000000, 10);
        op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        // DIV 7 / -2: quotient truncates toward zero, remainder follows dividend
        push(32'd0, 32'h80000000, 32'd1, 32'hFFFFFFFD, 10);
        op(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_idle();

        // op 6 is a no-op
        op(3'd6, 32'hAAAA, 32'hBBBB);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_hi", hi, 32'd1);
        chk("noop_lo", lo, 32'hFFFFFFFD);

        // DIV 100/7 aborted by reset in busy cycle 4
        push(32'd1, 32'hFFFFFFFD, 32'd0, 32'd0, 4);
        op(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("no_late_busy", {31'd0, busy}, 32'd0);
        end
        chk("no_late_hi", hi, 32'd0);
        chk("no_late_lo", lo, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the 5-stage pipeline's E stage. Accepts one multiply, divide or HI/LO-move command per start pulse and owns the HI and LO architectural registers. Models fixed multi-cycle latency with an internal counter, and exports `busy` plus `md_active` so the hazard unit stalls later MD instructions in D. Provides the MFHI/MFLO read value to the E-stage result mux.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  command valid for one cycle. Driven by E stage, already gated by stall/flush.
- `md_op`  in  3  command code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- `src_a`  in  32  rs operand, forwarded value.
- `src_b`  in  32  rt operand, forwarded value.
- `rd_hi`  in  1  read select: 1 selects HI, 0 selects LO.
- `busy`  out  1  a multi-cycle operation is in flight.
- `md_active`  out  1  equals `start | busy`; consumed by the hazard unit for D-stage stall.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `rd_data`  out  32  combinational: `rd_hi ? hi : lo`.

## Operation
- States: IDLE and RUN. `busy` = (state == RUN).
- IDLE, `start`=1, MULT/MULTU/DIV/DIVU:
  - Latch op result into pending HI/LO registers.
  - Load `cnt` = cycles−1.
  - Go to RUN.
- IDLE, `start`=1, MTHI/MTLO:
  - Write `src_a` into HI or LO at this edge.
  - Stay in IDLE; `busy` stays 0.
- IDLE, `start`=1, op 6–7: no state change.
- RUN:
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0, copy pending values into HI/LO and go to IDLE at the same edge.
- `start` while in RUN is ignored: no latch, no restart, no HI/LO write. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
- Arithmetic:
  - MULT: 64-bit product of signed a×b; HI = [63:32], LO = [31:0].
  - MULTU: same with unsigned operands.
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder, which takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero: the unit still enters RUN for DIV_CYCLES cycles; HI and LO are left unchanged at commit.
- Pending registers are internal only. `hi` and `lo` show architectural values until commit.
- Reset (`reset`=0 at an edge): state = IDLE, `cnt` = 0, HI = LO = pending = 0. Reset overrides `start` and any in-flight operation; the aborted result is never committed.

## Timing
- Reset values: `busy`=0, `md_active`=0 (when `start`=0), `hi`=0, `lo`=0, `rd_data`=0.
- Start sampled at edge E0. `busy`=1 in the N cycles following E0, where N = MULT_CYCLES or DIV_CYCLES.
- At edge E_N, `busy` falls and HI/LO update together. The new values are visible in the first cycle with `busy`=0.
- `md_active` is 1 in the start cycle (combinational from `start`) and in every busy cycle. It has no gap between the start cycle and the first busy cycle.
- A new `start` is accepted in the first cycle after `busy` falls. Back-to-back operations therefore have a period of N+1 cycles.
- MTHI/MTLO have latency 1: the value is visible in `hi`/`lo` in the cycle after the start edge.
- `rd_data` has zero latency from `rd_hi`, `hi` and `lo`.

## Test plan
- Reset sequence: hold `reset`=0 for 2 cycles after arbitrary activity. Then `hi`=`lo`=0, `busy`=0 and `md_active`=0.
- MULT with `src_a`=0xFFFFFFFD (−3), `src_b`=5:
  - `busy`=1 for exactly 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - `hi`/`lo` keep their old values while `busy`=1.
- Division:
  - DIV −7/2: after 10 busy cycles, `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF.
  - DIVU 7/2: `lo`=3, `hi`=1.
  - DIVU by 0 with HI=0x11, LO=0x22: 10 busy cycles, then HI/LO remain 0x11/0x22.
- MTHI 0xDEADBEEF:
  - `busy` never asserts.
  - The next cycle, `hi`=0xDEADBEEF, and `rd_data` is 0xDEADBEEF when `rd_hi`=1.
  - An immediately following MULTU 0xFFFFFFFF×2 is accepted and gives `hi`=1, `lo`=0xFFFFFFFE.
- Start ignored while busy: MULT 2×3, then `start` with MTLO 0x55 in busy cycle 2. Final `lo`=6, `hi`=0, and total busy time is 5 cycles.
- Reset mid-operation: DIV 100/7, with `reset`=0 in busy cycle 4. The next cycle has `busy`=0 and `hi`=`lo`=0; no late commit follows.
